keypoint_writer: RTL and testbench
==================================

# keypoint_writer

Keypoint BRAM writer for the SIFT pipeline. It accepts detected keypoints from the extrema detector over a valid/ready stream and buffers them in a small FIFO. It packs each keypoint into the octave-specific word format and writes the words sequentially into the keypoint BRAM, which `generate_descriptors` reads. It also reports the keypoint count and per-octave base addresses, and signals completion once all keypoints are written.

## Interface
- `DIMENSION`, 64: top-octave image width/height; `LOG = $clog2(DIMENSION)`
- `NUMBER_KEYPOINTS`, 1000: BRAM capacity in keypoints
- `FIFO_DEPTH`, 4: input buffer depth (power of two, ≥2)
- `clk`  in  1  system clock
- `rst_in_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  pulse; begins a session
- `kp_valid`  in  1  keypoint present
- `kp_ready`  out  1  block can accept a keypoint
- `kp_octave`  in  2  0=O1, 1=O2, 2=O3; 3 is invalid
- `kp_level`  in  1  DoG level within the octave
- `kp_x`, `kp_y`  in  LOG each  coordinates, LSB-aligned, at octave resolution
- `detect_done`  in  1  pulse; detector has issued its last keypoint
- `key_write_addr`  out  `$clog2(DIMENSION*DIMENSION)`  BRAM write address
- `key_wea`  out  1  BRAM write enable
- `key_write`  out  2*LOG+1  packed keypoint word
- `key_count`  out  `$clog2(NUMBER_KEYPOINTS+1)`  keypoints written this session
- `o2_base`, `o3_base`  out  `$clog2(DIMENSION*DIMENSION)`  first BRAM index of O2 and O3
- `overflow`  out  1  sticky; a keypoint was dropped because the BRAM was full
- `order_err`  out  1  sticky; a keypoint was dropped for a decreasing or invalid octave
- `keypoints_done`  out  1  level; the session is complete

## Operation
- **Reset values:** all outputs 0; state IDLE; FIFO empty; `cur_octave` = 0.
- **States:** IDLE, RUN, DRAIN, TERM, DONE.
- **IDLE or DONE, on `start`:** clear FIFO, `key_count`, bases, sticky flags and `keypoints_done`; set `cur_octave` = 0; go to RUN.
- **`start` in RUN, DRAIN or TERM:** ignored.
- **`kp_ready`:** equals (state==RUN && FIFO not full). A transfer occurs on `kp_valid && kp_ready`.
- **`detect_done` in RUN:** go to DRAIN; `kp_ready` drops the next cycle. A keypoint transferred in the same cycle as `detect_done` is kept.
- **Pop:** in RUN or DRAIN, one FIFO entry is popped per cycle while the FIFO is not empty. For a popped entry:
  - Octave 3 or octave < `cur_octave`: drop it and set `order_err`.
  - Octave > `cur_octave`: for each octave o in (`cur_octave`, octave], set base[o] = `key_count`. Then set `cur_octave` = octave.
  - `key_count` == NUMBER_KEYPOINTS: drop it and set `overflow`.
  - Otherwise: write `key_write_addr` = `key_count`, increment `key_count`, assert `key_wea` for one cycle.
- **Packing:** W = LOG − octave. `key_write` = {zero pad, x[W-1:0], y[W-1:0], level}; bits above 2W are zero. With LOG=6: O1 x[12:7] y[6:1]; O2 x[10:6] y[5:1]; O3 x[8:5] y[4:1]; level always at bit 0.
- **DRAIN to TERM:** when the FIFO is empty.
- **TERM:** octaves not yet reached get base = `key_count`. Then handle the terminator (see Configuration) and go to DONE.
- **DONE:** `keypoints_done` = 1 and is held until the next `start`.
- **Reset mid-session:** the session is abandoned and all outputs return to their reset values immediately. Writes already in BRAM are not undone.

## Timing
- **Latency:** a keypoint transferred in cycle N into an empty FIFO is written in cycle N+1. `key_wea`, `key_write` and `key_write_addr` are registered.
- **Throughput:** one keypoint per cycle sustained. A push and a pop in the same cycle are both honoured.
- **Full FIFO:** `kp_ready` is 0 while the FIFO is full.
- **Outputs during a write:** `key_count` and the base outputs update in the same cycle as the corresponding `key_wea`.
- **Completion:** `keypoints_done` rises one cycle after TERM is entered, or two cycles if a terminator is written.

## Configuration
- **`KEYPOINT_TERMINATOR_EN` defined:** in TERM, if `key_count` < NUMBER_KEYPOINTS, write an all-ones word at `key_count` for one cycle. `key_count` is not incremented.
- **Not defined:** TERM writes nothing and goes directly to DONE.

## Test plan
- Reset, `start`, push O1 (level 1, x=5, y=9) -> `key_wea` at addr 0 with word 659, one cycle after the transfer; `key_count`=1.
- Push O1 ×2, then O2 (x=3, y=4, level 0), then O3 (x=15, y=15, level 1) -> O2 word 200 at addr 2, O3 word 511 at addr 3; `o2_base`=2, `o3_base`=3.
- Hold `kp_valid` high for 10 cycles with a continuous stream -> 10 consecutive writes at addrs 0–9; `kp_ready` never deasserts.
- NUMBER_KEYPOINTS=4, push 6 keypoints, then `detect_done` -> 4 writes; `overflow`=1; `key_count`=4; `keypoints_done`=1; no terminator write.
- Push O2, then O1, then octave 3 -> only the O2 entry is written; `order_err`=1; `o2_base`=0; `o3_base`=1 at done.
- `detect_done` with 3 entries in the FIFO, with `KEYPOINT_TERMINATOR_EN` defined -> 3 writes, then 0x1FFF at addr 3, then `keypoints_done`. Assert `rst_in_n` low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/keypoint_writer_if.sv
// Keypoint stream from the extrema detector to the keypoint BRAM writer.
// The detector drives the master side; keypoint_writer uses the slave side.
interface keypoint_writer_if #(
    parameter int LOG = 6
);
    logic           kp_valid;
    logic           kp_ready;
    logic [1:0]     kp_octave;
    logic           kp_level;
    logic [LOG-1:0] kp_x;
    logic [LOG-1:0] kp_y;

    modport master (output kp_valid, kp_octave, kp_level, kp_x, kp_y, input kp_ready);
    modport slave  (input kp_valid, kp_octave, kp_level, kp_x, kp_y, output kp_ready);
endinterface

// File: rtl/keypoint_writer.sv
// Buffers detected keypoints, packs them per octave and writes them sequentially into the keypoint BRAM.
// Optional macro KEYPOINT_TERMINATOR_EN appends an all-ones terminator word after the last keypoint.
module keypoint_writer #(
    parameter int DIMENSION        = 64,
    parameter int NUMBER_KEYPOINTS = 1000,
    parameter int FIFO_DEPTH       = 4,
    localparam int LOG = $clog2(DIMENSION),
    localparam int AW  = $clog2(DIMENSION*DIMENSION),
    localparam int CW  = $clog2(NUMBER_KEYPOINTS+1),
    localparam int WW  = 2*LOG+1
) (
    input  logic            clk,
    input  logic            rst_in_n,
    input  logic            start,
    keypoint_writer_if.slave kp,
    input  logic            detect_done,
    output logic [AW-1:0]   key_write_addr,
    output logic            key_wea,
    output logic [WW-1:0]   key_write,
    output logic [CW-1:0]   key_count,
    output logic [AW-1:0]   o2_base,
    output logic [AW-1:0]   o3_base,
    output logic            overflow,
    output logic            order_err,
    output logic            keypoints_done
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, TERM, DONE} state_t;

    typedef struct packed {
        logic [1:0]     octave;
        logic           level;
        logic [LOG-1:0] x;
        logic [LOG-1:0] y;
    } entry_t;

    state_t     state;
    logic [1:0] cur_octave;
    logic [PW:0] wr_ptr, rd_ptr;
    entry_t     mem [FIFO_DEPTH];
`ifdef KEYPOINT_TERMINATOR_EN
    logic       term_pending;
`endif

    logic   fifo_empty, fifo_full, push, bypass, pop;
    entry_t in_entry, head;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign kp.kp_ready = (state == RUN) && !fifo_full;
    assign push        = kp.kp_valid && kp.kp_ready;
    assign in_entry    = {kp.kp_octave, kp.kp_level, kp.kp_x, kp.kp_y};
    // An arrival into an empty FIFO is processed directly so it is written the very next cycle.
    assign bypass      = fifo_empty && push;
    assign pop         = ((state == RUN) || (state == DRAIN)) && (!fifo_empty || push);
    assign head        = fifo_empty ? in_entry : mem[rd_ptr[PW-1:0]];

    // Coordinates shrink by one bit per octave: {x[W-1:0], y[W-1:0], level} with W = LOG - octave.
    function automatic logic [WW-1:0] pack(input entry_t e);
        int            w;
        logic [WW-1:0] mask, xw, yw;
        w    = LOG - int'(e.octave);
        mask = (WW'(1) << w) - WW'(1);
        xw   = WW'(e.x) & mask;
        yw   = WW'(e.y) & mask;
        return (xw << (w + 1)) | (yw << 1) | WW'(e.level);
    endfunction

    always_ff @(posedge clk) begin
        if (push && !bypass)
            mem[wr_ptr[PW-1:0]] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state          <= IDLE;
            cur_octave     <= 2'd0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            key_write_addr <= '0;
            key_wea        <= 1'b0;
            key_write      <= '0;
            key_count      <= '0;
            o2_base        <= '0;
            o3_base        <= '0;
            overflow       <= 1'b0;
            order_err      <= 1'b0;
            keypoints_done <= 1'b0;
`ifdef KEYPOINT_TERMINATOR_EN
            term_pending   <= 1'b0;
`endif
        end else begin
            key_wea <= 1'b0;
            if (push && !bypass)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !fifo_empty)
                rd_ptr <= rd_ptr + 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        wr_ptr         <= '0;
                        rd_ptr         <= '0;
                        key_count      <= '0;
                        o2_base        <= '0;
                        o3_base        <= '0;
                        overflow       <= 1'b0;
                        order_err      <= 1'b0;
                        keypoints_done <= 1'b0;
                        cur_octave     <= 2'd0;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    if (detect_done)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty)
                        state <= TERM;
                end
                TERM: begin
                    if (cur_octave < 2'd1) o2_base <= AW'(key_count);
                    if (cur_octave < 2'd2) o3_base <= AW'(key_count);
`ifdef KEYPOINT_TERMINATOR_EN
                    if (term_pending) begin
                        term_pending   <= 1'b0;
                        keypoints_done <= 1'b1;
                        state          <= DONE;
                    end else if (key_count < CW'(NUMBER_KEYPOINTS)) begin
                        key_wea        <= 1'b1;
                        key_write_addr <= AW'(key_count);
                        key_write      <= '1;
                        term_pending   <= 1'b1;
                    end else begin
                        keypoints_done <= 1'b1;
                        state          <= DONE;
                    end
`else
                    keypoints_done <= 1'b1;
                    state          <= DONE;
`endif
                end
                default: state <= IDLE;
            endcase

            // Octave changes fill in the base of every octave stepped over, even if the entry is then dropped.
            if (pop) begin
                if ((head.octave == 2'd3) || (head.octave < cur_octave)) begin
                    order_err <= 1'b1;
                end else begin
                    if (head.octave > cur_octave) begin
                        if ((cur_octave < 2'd1) && (head.octave >= 2'd1)) o2_base <= AW'(key_count);
                        if ((cur_octave < 2'd2) && (head.octave >= 2'd2)) o3_base <= AW'(key_count);
                        cur_octave <= head.octave;
                    end
                    if (key_count == CW'(NUMBER_KEYPOINTS)) begin
                        overflow <= 1'b1;
                    end else begin
                        key_wea        <= 1'b1;
                        key_write_addr <= AW'(key_count);
                        key_write      <= pack(head);
                        key_count      <= key_count + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_keypoint_writer.sv
// Self-checking bench for keypoint_writer: a main instance (1000 keypoints) and a 4-keypoint instance sharing stimulus.
module tb_keypoint_writer;
`ifdef KEYPOINT_TERMINATOR_EN
    localparam int TERM_W = 1;
`else
    localparam int TERM_W = 0;
`endif
    localparam int TERM_WORD = 8191;

    logic        clk = 1'b0;
    logic        rst_n, start, detect_done;
    logic [11:0] key_write_addr, o2_base, o3_base, key_write_addr_o, o2_base_o, o3_base_o;
    logic        key_wea, overflow, order_err, keypoints_done;
    logic        key_wea_o, overflow_o, order_err_o, keypoints_done_o;
    logic [12:0] key_write, key_write_o;
    logic [9:0]  key_count;
    logic [2:0]  key_count_o;

    int errors = 0;
    int checks = 0;
    int q_addr[$], q_word[$], q_addr_o[$], q_word_o[$];

    keypoint_writer_if #(.LOG(6)) kp_if ();
    keypoint_writer_if #(.LOG(6)) kp_o ();

    assign kp_o.kp_valid  = kp_if.kp_valid;
    assign kp_o.kp_octave = kp_if.kp_octave;
    assign kp_o.kp_level  = kp_if.kp_level;
    assign kp_o.kp_x      = kp_if.kp_x;
    assign kp_o.kp_y      = kp_if.kp_y;

    keypoint_writer #(.DIMENSION(64), .NUMBER_KEYPOINTS(1000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_in_n(rst_n), .start(start), .kp(kp_if), .detect_done(detect_done),
        .key_write_addr(key_write_addr), .key_wea(key_wea), .key_write(key_write),
        .key_count(key_count), .o2_base(o2_base), .o3_base(o3_base),
        .overflow(overflow), .order_err(order_err), .keypoints_done(keypoints_done)
    );

    keypoint_writer #(.DIMENSION(64), .NUMBER_KEYPOINTS(4), .FIFO_DEPTH(4)) dut_o (
        .clk(clk), .rst_in_n(rst_n), .start(start), .kp(kp_o), .detect_done(detect_done),
        .key_write_addr(key_write_addr_o), .key_wea(key_wea_o), .key_write(key_write_o),
        .key_count(key_count_o), .o2_base(o2_base_o), .o3_base(o3_base_o),
        .overflow(overflow_o), .order_err(order_err_o), .keypoints_done(keypoints_done_o)
    );

    always #5 clk = ~clk;

    // Record every BRAM write of both instances.
    always @(negedge clk) begin
        if (key_wea) begin
            q_addr.push_back(int'(key_write_addr));
            q_word.push_back(int'(key_write));
        end
        if (key_wea_o) begin
            q_addr_o.push_back(int'(key_write_addr_o));
            q_word_o.push_back(int'(key_write_o));
        end
    end

    typedef struct {
        int st, vld, oct, lvl, x, y, dd;
        int e_rdy, e_wea, e_addr, e_word, e_cnt, e_o2, e_o3, e_done;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int st, input int vld, input int oct, input int lvl,
                                 input int x, input int y, input int dd);
        @(posedge clk);
        #1;
        start             = 1'(st);
        kp_if.kp_valid    = 1'(vld);
        kp_if.kp_octave   = 2'(oct);
        kp_if.kp_level    = 1'(lvl);
        kp_if.kp_x        = 6'(x);
        kp_if.kp_y        = 6'(y);
        detect_done       = 1'(dd);
    endtask

    task automatic clearQueues();
        q_addr.delete(); q_word.delete(); q_addr_o.delete(); q_word_o.delete();
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!keypoints_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_reached", int'(keypoints_done), 1);
    endtask

    function automatic int streamWord(input int i);
        return ((i + 1) << 7) | ((2 * i) << 1) | (i % 2);
    endfunction

    initial begin
        //              st vld oct lvl  x   y  dd  rdy wea addr word cnt o2 o3 done
        vecs[0] = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0};
        vecs[1] = '{0, 1, 0, 1, 5, 9, 0,   1, 0, 0, 0,   0, 0, 0, 0};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 659, 1, 0, 0, 0};
        vecs[3] = '{0, 1, 0, 0, 1, 1, 0,   1, 0, 0, 0,   1, 0, 0, 0};
        vecs[4] = '{0, 1, 1, 0, 3, 4, 0,   1, 1, 1, 130, 2, 0, 0, 0};
        vecs[5] = '{0, 1, 2, 1, 15, 15, 0, 1, 1, 2, 200, 3, 2, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 1,   1, 1, 3, 511, 4, 2, 3, 0};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   4, 2, 3, 0};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   4, 2, 3, 0};

        rst_n = 1'b0;
        start = 1'b0; detect_done = 1'b0;
        kp_if.kp_valid = 1'b0; kp_if.kp_octave = 2'd0; kp_if.kp_level = 1'b0;
        kp_if.kp_x = 6'd0; kp_if.kp_y = 6'd0;
        #12;
        checkOutput("reset_wea", int'(key_wea), 0);
        checkOutput("reset_ready", int'(kp_if.kp_ready), 0);
        checkOutput("reset_count", int'(key_count), 0);
        checkOutput("reset_done", int'(keypoints_done), 0);
        rst_n = 1'b1;

        $display("[TB] session 1: table-driven packing and bases");
        clearQueues();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].st, vecs[i].vld, vecs[i].oct, vecs[i].lvl, vecs[i].x, vecs[i].y, vecs[i].dd);
            @(negedge clk);
            checkOutput($sformatf("v%0d_ready", i), int'(kp_if.kp_ready), vecs[i].e_rdy);
            checkOutput($sformatf("v%0d_wea", i), int'(key_wea), vecs[i].e_wea);
            if (vecs[i].e_wea != 0) begin
                checkOutput($sformatf("v%0d_addr", i), int'(key_write_addr), vecs[i].e_addr);
                checkOutput($sformatf("v%0d_word", i), int'(key_write), vecs[i].e_word);
            end
            checkOutput($sformatf("v%0d_count", i), int'(key_count), vecs[i].e_cnt);
            checkOutput($sformatf("v%0d_o2", i), int'(o2_base), vecs[i].e_o2);
            checkOutput($sformatf("v%0d_o3", i), int'(o3_base), vecs[i].e_o3);
            checkOutput($sformatf("v%0d_done", i), int'(keypoints_done), vecs[i].e_done);
        end
`ifdef KEYPOINT_TERMINATOR_EN
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s1_term_wea", int'(key_wea), 1);
        checkOutput("s1_term_addr", int'(key_write_addr), 4);
        checkOutput("s1_term_word", int'(key_write), TERM_WORD);
        checkOutput("s1_term_done_early", int'(keypoints_done), 0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s1_done", int'(keypoints_done), 1);
        checkOutput("s1_done_wea", int'(key_wea), 0);
        checkOutput("s1_ovf_count", int'(key_count_o), 4);
        checkOutput("s1_ovf_flag", int'(overflow_o), 0);
        checkOutput("s1_ovf_done", int'(keypoints_done_o), 1);

        $display("[TB] session 2: sustained stream of 10 keypoints");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        clearQueues();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, i % 2, i + 1, 2 * i, 0);
            @(negedge clk);
            checkOutput($sformatf("s2_ready%0d", i), int'(kp_if.kp_ready), 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitDone(20);
        checkOutput("s2_nwrites", q_addr.size(), 10 + TERM_W);
        for (int i = 0; i < 10 && i < q_addr.size(); i++) begin
            checkOutput($sformatf("s2_addr%0d", i), q_addr[i], i);
            checkOutput($sformatf("s2_word%0d", i), q_word[i], streamWord(i));
        end
        checkOutput("s2_count", int'(key_count), 10);
        checkOutput("ovf_nwrites", q_addr_o.size(), 4);
        for (int i = 0; i < 4 && i < q_addr_o.size(); i++) begin
            checkOutput($sformatf("ovf_addr%0d", i), q_addr_o[i], i);
            checkOutput($sformatf("ovf_word%0d", i), q_word_o[i], streamWord(i));
        end
        checkOutput("ovf_flag", int'(overflow_o), 1);
        checkOutput("ovf_count", int'(key_count_o), 4);
        checkOutput("ovf_done", int'(keypoints_done_o), 1);
        checkOutput("ovf_order_err", int'(order_err_o), 0);

        $display("[TB] session 3: octave ordering");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        clearQueues();
        applyStimulus(0, 1, 1, 1, 1, 2, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitDone(20);
        checkOutput("s3_nwrites", q_addr.size(), 1 + TERM_W);
        if (q_addr.size() > 0) begin
            checkOutput("s3_addr", q_addr[0], 0);
            checkOutput("s3_word", q_word[0], 69);
        end
        checkOutput("s3_order_err", int'(order_err), 1);
        checkOutput("s3_overflow", int'(overflow), 0);
        checkOutput("s3_o2", int'(o2_base), 0);
        checkOutput("s3_o3", int'(o3_base), 1);
        checkOutput("s3_count", int'(key_count), 1);

        $display("[TB] session 4: detect_done with the last transfer");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        clearQueues();
        applyStimulus(0, 1, 0, 0, 2, 3, 0);
        applyStimulus(0, 1, 0, 1, 63, 0, 0);
        applyStimulus(0, 1, 1, 0, 31, 31, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitDone(20);
        checkOutput("s4_nwrites", q_addr.size(), 3 + TERM_W);
        if (q_addr.size() >= 3) begin
            checkOutput("s4_word0", q_word[0], 262);
            checkOutput("s4_word1", q_word[1], 8065);
            checkOutput("s4_word2", q_word[2], 2046);
            checkOutput("s4_addr2", q_addr[2], 2);
        end
`ifdef KEYPOINT_TERMINATOR_EN
        if (q_addr.size() >= 4) begin
            checkOutput("s4_term_addr", q_addr[3], 3);
            checkOutput("s4_term_word", q_word[3], TERM_WORD);
        end
`endif
        checkOutput("s4_o2", int'(o2_base), 2);
        checkOutput("s4_o3", int'(o3_base), 3);
        checkOutput("s4_count", int'(key_count), 3);

        $display("[TB] session 5: asynchronous reset mid-stream");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 7, 7, 0);
        applyStimulus(0, 1, 1, 1, 7, 7, 0);
        applyStimulus(0, 1, 2, 1, 7, 7, 0);
        @(posedge clk);
        #2;
        checkOutput("s5_pre_count", int'(key_count), 3);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_wea", int'(key_wea), 0);
        checkOutput("s5_rst_addr", int'(key_write_addr), 0);
        checkOutput("s5_rst_word", int'(key_write), 0);
        checkOutput("s5_rst_count", int'(key_count), 0);
        checkOutput("s5_rst_o2", int'(o2_base), 0);
        checkOutput("s5_rst_o3", int'(o3_base), 0);
        checkOutput("s5_rst_ready", int'(kp_if.kp_ready), 0);
        checkOutput("s5_rst_flags", int'({overflow, order_err, keypoints_done}), 0);
        kp_if.kp_valid = 1'b0;
        #10;
        rst_n = 1'b1;

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
